// File: rtl/mem_handshake_ctrl_pkg.sv
// mem_handshake_ctrl_pkg
//   Shared definitions for the memory handshake sequencer: transfer size
//   encodings, R/W polarity, FSM state type and small beat helpers.
package mem_handshake_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is reserved and handled as a word

  localparam logic RW_READ = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Index of the final beat for a transfer size (beats - 1).
  function automatic logic [1:0] last_beat_of(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Byte lane of a 32-bit word, lane 0 = bits [7:0].
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_handshake_ctrl_wait.sv
// mem_wait_counter
//   Loadable down-counter used to time the RAM read latency of each beat.
//   Ports:
//     clk, reset      clock, asynchronous active-low reset
//     load, load_val  load the count (takes priority over dec)
//     dec             decrement, saturating at zero
//     zero            count is zero (decoded from the register)
module mem_wait_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_handshake_ctrl.sv
// mem_handshake_ctrl
//   Sequencer between the microprogrammed control unit and a byte-wide
//   synchronous data RAM. A request qualified by mov is split into
//   big-endian byte beats (beat 0 = most significant byte) and completion
//   is returned on moc with a four-phase handshake.
//   Ports:
//     clk, reset        clock, asynchronous active-low reset
//     mov, rw, size     request valid, 1=read/0=write, 00 byte/01 half/1x word
//     addr, wdata       byte address (MAR) and write data (MDR)
//     moc, rdata, busy  completion, read result (zero-extended), not-idle
//     ram_en, ram_we    one-cycle beat strobe and its write enable
//     ram_addr          beat address
//     ram_wdata         beat write byte
//     ram_rdata         read byte, valid WAIT_CYCLES cycles after ram_en
module mem_handshake_ctrl
  import mem_handshake_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mov,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              moc,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  state_t            state;
  logic              rw_q;
  logic [1:0]        last_beat_q;
  logic [1:0]        beat_q;
  logic [1:0]        next_beat;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] aligned_addr;
  logic [31:0]       wdata_q;
  logic [23:0]       asm_q;
  logic              wait_zero;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    aligned_addr = addr;
    if (size == SZ_HALF) begin
      aligned_addr[0] = 1'b0;
    end else if (size != SZ_BYTE) begin
      aligned_addr[1:0] = 2'b00;
    end
  end

  assign next_beat = beat_q + 2'd1;

  // The counter is loaded while in ISSUE with the number of WAIT cycles
  // still to follow the first one, so zero marks the last WAIT cycle.
  mem_wait_counter #(
    .W(3)
  ) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_ISSUE),
    .load_val (3'(WAIT_CYCLES - 1)),
    .dec      (state == ST_WAIT),
    .zero     (wait_zero)
  );

  // NOTE: the latched request and assembly registers are reset as well so
  // that outputs are deterministic out of reset; they are a few flops only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rw_q        <= RW_READ;
      last_beat_q <= 2'd0;
      beat_q      <= 2'd0;
      base_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      moc         <= 1'b0;
      busy        <= 1'b0;
      rdata       <= '0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
    end else begin
      // Beat strobe lasts exactly the ISSUE cycle.
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mov) begin
            rw_q        <= rw;
            last_beat_q <= last_beat_of(size);
            beat_q      <= 2'd0;
            base_q      <= aligned_addr;
            wdata_q     <= wdata;
            asm_q       <= '0;
            busy        <= 1'b1;
            ram_en      <= 1'b1;
            ram_we      <= (rw != RW_READ);
            ram_addr    <= aligned_addr;
            ram_wdata   <= byte_sel(wdata, last_beat_of(size));
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_zero) begin
            if (rw_q == RW_READ) begin
              asm_q <= {asm_q[15:0], ram_rdata};
            end
            if (beat_q == last_beat_q) begin
              // Assembly register starts at zero, giving zero extension.
              if (rw_q == RW_READ) begin
                rdata <= {asm_q, ram_rdata};
              end
              moc   <= 1'b1;
              state <= ST_DONE;
            end else begin
              beat_q    <= next_beat;
              ram_en    <= 1'b1;
              ram_we    <= (rw_q != RW_READ);
              ram_addr  <= base_q + ADDR_W'(next_beat);
              ram_wdata <= byte_sel(wdata_q, last_beat_q - next_beat);
              state     <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          if (!mov) begin
            moc   <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// tb_mem_handshake_ctrl
//   Two instances share the clock and reset: dut index 0 with WAIT_CYCLES=1
//   and index 1 with WAIT_CYCLES=3. Expected RAM beats and read results are
//   queued when a request is driven and popped as the DUT produces them.
module tb_mem_handshake_ctrl;

  typedef struct packed {
    logic [7:0] addr;
    logic       we;
    logic [7:0] data;
  } beat_t;

  logic        clk;
  logic        reset;
  logic        mov       [2];
  logic        rw        [2];
  logic [1:0]  size      [2];
  logic [7:0]  addr      [2];
  logic [31:0] wdata     [2];
  logic        moc       [2];
  logic [31:0] rdata     [2];
  logic        busy      [2];
  logic        ram_en    [2];
  logic        ram_we    [2];
  logic [7:0]  ram_addr  [2];
  logic [7:0]  ram_wdata [2];
  logic [7:0]  ram_rdata [2];

  beat_t       exp_beats[$];
  logic [31:0] exp_rdata[$];
  logic [31:0] last_rdata [2];
  int          n_checks = 0;
  int          n_fail   = 0;

  mem_handshake_ctrl #(.ADDR_W(8), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset), .mov(mov[0]), .rw(rw[0]), .size(size[0]),
    .addr(addr[0]), .wdata(wdata[0]), .moc(moc[0]), .rdata(rdata[0]),
    .busy(busy[0]), .ram_en(ram_en[0]), .ram_we(ram_we[0]),
    .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
  );

  mem_handshake_ctrl #(.ADDR_W(8), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .mov(mov[1]), .rw(rw[1]), .size(size[1]),
    .addr(addr[1]), .wdata(wdata[1]), .moc(moc[1]), .rdata(rdata[1]),
    .busy(busy[1]), .ram_en(ram_en[1]), .ram_we(ram_we[1]),
    .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents as a pure function of address.
  function automatic logic [7:0] ram_byte(input logic [7:0] a);
    case (a)
      8'h10:   return 8'hA5;
      8'h20:   return 8'h11;
      8'h21:   return 8'h22;
      8'h22:   return 8'h33;
      8'h23:   return 8'h44;
      default: return a ^ 8'h3C;
    endcase
  endfunction

  // Synchronous RAM read pipeline, latency W cycles from the ram_en cycle.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    localparam int W = (g == 0) ? 1 : 3;
    logic [7:0] pipe [W];
    always @(posedge clk) begin
      pipe[0] <= ram_en[g] ? ram_byte(ram_addr[g]) : 8'hEE;
      for (int i = 1; i < W; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata[g] = pipe[W-1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_txn(input int d, input logic r, input logic [1:0] sz,
                         input logic [7:0] a, input logic [31:0] wd,
                         input int hold, input bit early_drop);
    int          nb, lat, edges, seen;
    logic [7:0]  base;
    logic [31:0] model;
    beat_t       bt;
    bit          done;
    nb    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base  = (nb == 4) ? {a[7:2], 2'b00} : (nb == 2) ? {a[7:1], 1'b0} : a;
    lat   = 1 + nb * (1 + ((d == 0) ? 1 : 3));
    model = '0;
    for (int b = 0; b < nb; b++) begin
      bt.addr = base + 8'(b);
      bt.we   = ~r;
      bt.data = wd[8*(nb-1-b) +: 8];
      exp_beats.push_back(bt);
      model = {model[23:0], ram_byte(bt.addr)};
    end
    if (r) last_rdata[d] = model;
    exp_rdata.push_back(last_rdata[d]);

    @(negedge clk);
    mov[d] = 1'b1; rw[d] = r; size[d] = sz; addr[d] = a; wdata[d] = wd;
    edges = 0; seen = 0; done = 1'b0;
    while (!done && edges < 64) begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        check("busy_after_accept", busy[d], 1);
        rw[d] = ~r; size[d] = ~sz; addr[d] = 8'($urandom); wdata[d] = $urandom;
        if (early_drop) mov[d] = 1'b0;
      end
      if (ram_en[d]) begin
        seen++;
        if (exp_beats.size() != 0) begin
          bt = exp_beats.pop_front();
          check("beat_addr", ram_addr[d], bt.addr);
          check("beat_we", ram_we[d], bt.we);
          if (bt.we) check("beat_wdata", ram_wdata[d], bt.data);
        end
      end
      if (moc[d]) done = 1'b1;
    end
    check("beat_count", seen, nb);
    check("moc_latency", edges, lat);
    check("rdata", rdata[d], exp_rdata.pop_front());
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check("moc_held", moc[d], 1);
      check("no_beat_in_done", ram_en[d], 0);
    end
    mov[d] = 1'b0;
    @(negedge clk);
    check("moc_clear", moc[d], 0);
    check("busy_clear", busy[d], 0);
    exp_beats.delete();
  endtask

  initial begin
    int edges, seen;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mov[d] = 1'b0; rw[d] = 1'b1; size[d] = 2'b00; addr[d] = '0; wdata[d] = '0;
      last_rdata[d] = '0;
    end
    #12;
    check("rst_moc", moc[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_rdata", rdata[0], 32'h0);
    check("rst_ram_en", ram_en[0], 0);
    check("rst_ram_we", ram_we[0], 0);
    check("rst_ram_addr", ram_addr[0], 8'h00);
    check("rst_ram_wdata", ram_wdata[0], 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // WAIT_CYCLES = 1
    run_txn(0, 1'b1, 2'b00, 8'h10, 32'h0,        1, 1'b0);  // byte read
    run_txn(0, 1'b1, 2'b10, 8'h23, 32'h0,        1, 1'b0);  // word read, aligned down
    run_txn(0, 1'b0, 2'b01, 8'h41, 32'hDEADBEEF, 1, 1'b0);  // halfword write
    run_txn(0, 1'b1, 2'b01, 8'h5B, 32'h0,        4, 1'b0);  // moc held 4 cycles
    run_txn(0, 1'b0, 2'b10, 8'h07, 32'hCAFEF00D, 1, 1'b1);  // mov dropped early
    run_txn(0, 1'b0, 2'b00, 8'hFF, 32'h12345678, 1, 1'b0);  // byte write uses [7:0]
    run_txn(0, 1'b1, 2'b01, 8'hFF, 32'h0,        1, 1'b0);  // top halfword
    run_txn(0, 1'b1, 2'b11, 8'h31, 32'h0,        1, 1'b0);  // reserved size = word

    // Reset during the third beat of a word write.
    @(negedge clk);
    mov[0] = 1'b1; rw[0] = 1'b0; size[0] = 2'b10; addr[0] = 8'h80; wdata[0] = 32'hA1B2C3D4;
    edges = 0; seen = 0;
    while (seen < 3 && edges < 64) begin
      @(negedge clk);
      edges++;
      if (ram_en[0]) begin
        seen++;
        check("rst_txn_beat_addr", ram_addr[0], 8'h80 + 8'(seen - 1));
      end
    end
    check("rst_txn_third_beat", seen, 3);
    reset = 1'b0;
    #1;
    check("mid_rst_ram_en", ram_en[0], 0);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_moc", moc[0], 0);
    check("mid_rst_rdata", rdata[0], 32'h0);
    mov[0] = 1'b0;
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    @(negedge clk);
    reset = 1'b1;
    run_txn(0, 1'b1, 2'b00, 8'h10, 32'h0, 1, 1'b0);

    // WAIT_CYCLES = 3
    run_txn(1, 1'b1, 2'b10, 8'h20, 32'h0,        1, 1'b0);
    run_txn(1, 1'b0, 2'b01, 8'h62, 32'h0000BEEF, 2, 1'b0);
    run_txn(1, 1'b1, 2'b00, 8'h9C, 32'h0,        1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_handshake_ctrl.md
# mem_handshake_ctrl

Sequencer between the microprogrammed control unit and the byte-wide data RAM. Accepts a memory request qualified by MOV with R/W, size and address from MAR/MDR, splits it into big-endian byte beats on a synchronous RAM port, and returns MOC on a four-phase handshake. It is the sole producer of the control unit's MOC input.

## Interface
Parameters:
- ADDR_W, 8, RAM byte-address width.
- WAIT_CYCLES, 1, RAM read latency in cycles per beat (legal 1..7).

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- mov  in  1  request valid from control unit (MOV); held until moc seen.
- rw  in  1  1 = read, 0 = write (R/W).
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- addr  in  ADDR_W  byte address from MAR.
- wdata  in  32  write data from MDR.
- moc  out  1  memory operation complete.
- rdata  out  32  read result to MDR input.
- busy  out  1  high in any state other than IDLE.
- ram_en  out  1  one-cycle beat strobe.
- ram_we  out  1  write enable, valid with ram_en.
- ram_addr  out  ADDR_W  beat address.
- ram_wdata  out  8  beat write byte.
- ram_rdata  in  8  RAM read byte, valid WAIT_CYCLES cycles after ram_en.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: on edge with mov=1 latch rw, size, wdata, aligned base (word: addr[1:0]=0; halfword: addr[0]=0); beat←0; beats = 1/2/4; go ISSUE.
- ISSUE (one cycle): ram_en=1, ram_we=~rw, ram_addr=base+beat (mod 2^ADDR_W), ram_wdata = selected byte; go WAIT, wait count←WAIT_CYCLES.
- WAIT: decrement count; on edge ending last WAIT cycle, if read shift ram_rdata into assembly register; if beat = beats-1 go DONE (rdata←assembled, zero-extended), else beat+1, go ISSUE.
- DONE: moc=1. Leave to IDLE on edge with mov=0; stay while mov=1.
- Byte order big-endian: beat 0 = MSB. Word read rdata={b0,b1,b2,b3}; halfword {16'h0,b0,b1}; byte {24'h0,b0}. Halfword write: wdata[15:8] at base, wdata[7:0] at base+1; byte write uses wdata[7:0].
- Writes leave rdata unchanged.
- Inputs other than mov are ignored after acceptance; mov dropping before DONE does not abort: transaction completes, moc pulses one cycle, return to IDLE.

## Timing
- Reset values: state IDLE, moc 0, busy 0, rdata 32'h0, ram_en 0, ram_we 0, ram_addr 0, ram_wdata 0.
- All outputs registered or decoded from registered state only; no combinational path mov→moc.
- Latency from accepting edge to first moc=1 cycle: 1 + beats·(1+WAIT_CYCLES) edges. WAIT_CYCLES=1: byte 3, halfword 5, word 9.
- Back-to-back: new request accepted earliest on the edge after returning to IDLE (mov must be seen low once).
- Reset mid-transaction: immediate IDLE, ram_en drops asynchronously; partial RAM writes already issued stay.

## Structure
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, R/W polarity constant.
- One natural sub-module: mem_wait_counter (loadable down-counter with zero flag) used for WAIT.

## Test plan
- Byte read, RAM[0x10]=0xA5, WAIT_CYCLES=1 -> one ram_en at 0x10, moc on 3rd edge after accept, rdata=0x000000A5.
- Word read addr 0x23, RAM[0x20..0x23]=11,22,33,44 -> ram_addr 0x20..0x23, moc after 9 edges, rdata=0x11223344.
- Halfword write addr 0x41, wdata 0xDEADBEEF -> ram_we beats 0x40←0xBE, 0x41←0xEF; rdata unchanged.
- mov held high in DONE for 4 cycles -> moc held 4 cycles; mov low -> IDLE next edge, busy 0.
- reset low during 3rd beat of word write -> moc/ram_en/busy 0 immediately; new byte read after release completes normally.
- WAIT_CYCLES=3 word read -> each beat 4 cycles, moc after 17 edges, correct data.
